rtc_time_counter: RTL and testbench
===================================

// Module: rtc_time_counter
// PURPOSE
//   Real-time HH:MM:SS counter downstream of the clock divider. Consumes the divider's
//   toggling slow-clock output as a same-domain tick and edge-detects it. Prescales
//   edges to seconds and keeps binary sec/min/hour with carry and a settable time.
//   Feeds the display/BCD stage with time values and a 1-cycle sec_pulse.
// PARAMETERS
//   EDGES_PER_SEC  5   rising edges of tick_in per second (0.1 s toggle -> 5 edges/s)
//   HOUR_MAX       23  last hour value before wrap to 0
// PORTS
//   clk          in   1  system clock (50 MHz)
//   rst_n        in   1  synchronous, active-low reset
//   tick_in      in   1  divider toggle output, synchronous to clk
//   run          in   1  level: 1 = count, 0 = hold
//   load_valid   in   1  time-load request
//   load_ready   out  1  load can be accepted this cycle
//   load_hour    in   5  hour to load
//   load_min     in   6  minute to load
//   load_sec     in   6  second to load
//   load_err     out  1  1-cycle pulse: load rejected (out-of-range field)
//   hour         out  5  current hour, 0..HOUR_MAX
//   min          out  6  current minute, 0..59
//   sec          out  6  current second, 0..59
//   sec_pulse    out  1  1-cycle pulse on each counted second
// BEHAVIOUR
//   Reset (rst_n=0 at posedge clk): hour/min/sec=0, sec_pulse=0, load_err=0, load_ready=0,
//     tick_q=0, edge_cnt=0, state=STOP. load_ready=1 from first cycle after reset release.
//   Edge detect: tick_q <= tick_in; rise = tick_in & ~tick_q. rise may fire in the first
//     cycle after reset if tick_in=1.
//   FSM: STOP, RUN, LOAD.
//     STOP: run=1 -> RUN; accepted load -> LOAD. edge_cnt and time held.
//     RUN: run=0 -> STOP (edge_cnt held, not cleared); accepted load -> LOAD.
//     LOAD: lasts exactly 1 cycle; load_ready=0; rises ignored; -> RUN if run else STOP.
//   Handshake: accept = load_valid & load_ready (load_ready=1 in STOP/RUN).
//     On accept, fields range-checked (hour<=HOUR_MAX, min<=59, sec<=59):
//     ok -> time registered next cycle, edge_cnt=0; bad -> time unchanged,
//     load_err=1 next cycle, state still goes to LOAD.
//   Prescale (RUN only): on rise, edge_cnt==EDGES_PER_SEC-1 -> edge_cnt=0 and second
//     event; else edge_cnt+1. Second event: sec_pulse=1 next cycle, time advances.
//   Carry: sec 59->0 with min+1; min 59->0 with hour+1; hour HOUR_MAX->0. 23:59:59 -> 00:00:00.
//   Accept and second event same cycle: load wins, second dropped, sec_pulse=0.
//   run deasserted on the same cycle as a rise: rise is counted (state is still RUN).
//   Reset mid-operation: immediate return to reset values next clock; in-flight load dropped.
//   Latency: rise -> updated time/sec_pulse 1 cycle; accept -> loaded time 1 cycle.
// CONFIGURATION
//   RTC_ALARM_EN defined: adds ports alarm_on (in,1), alarm_hour (in,5), alarm_min (in,6),
//     alarm_hit (out,1). alarm_hit pulses 1 cycle, same cycle as sec_pulse, when counting
//     (not loading) reaches alarm_hour:alarm_min:00 and alarm_on=1. Reset value 0.
//   RTC_ALARM_EN undefined: alarm ports and logic absent; all else identical.
// TESTING
//   Reset release, run=1, 5 rises -> sec=1, one sec_pulse; 4 rises -> sec stays 0.
//   Load 23:59:59, run=1, 5 rises -> 00:00:00 with single sec_pulse.
//   load_valid with min=60 -> load_err 1 cycle, time unchanged, load_ready 0 one cycle.
//   Load accept on same cycle as 5th rise -> loaded value shown, no sec_pulse, edge_cnt=0.
//   run=0 after 3 rises, 10 rises, run=1, 2 rises -> exactly one sec increment.
//   RTC_ALARM_EN, alarm 00:01, from 00:00:59 one second -> alarm_hit with sec_pulse; alarm_on=0 -> none.

Source files
------------

// File: rtl/rtc_time_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rtc_time_counter
// Description : HH:MM:SS counter driven by edges of the divider's slow toggle,
//               with a settable time and an optional alarm (RTC_ALARM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_counter #(
    parameter int EDGES_PER_SEC = 5,
    parameter int HOUR_MAX      = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic       load_err,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_pulse
`ifdef RTC_ALARM_EN
    ,
    input  logic       alarm_on,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic       alarm_hit
`endif
);

    localparam int         c_CNT_W     = (EDGES_PER_SEC > 1) ? $clog2(EDGES_PER_SEC) : 1;
    localparam logic [c_CNT_W-1:0] c_EDGE_LAST = c_CNT_W'(EDGES_PER_SEC - 1);
    localparam logic [4:0] c_HOUR_MAX  = 5'(HOUR_MAX);
    localparam logic [5:0] c_MS_MAX    = 6'd59;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_tick_q;
    logic [c_CNT_W-1:0] r_edge_cnt;
    logic [4:0]         r_hour;
    logic [5:0]         r_min;
    logic [5:0]         r_sec;
    logic               r_sec_pulse;
    logic               r_load_err;
    logic               r_load_ready;

    logic               w_rise;
    logic               w_accept;
    logic               w_load_ok;
    logic               w_count;
    logic               w_sec_evt;
    logic [4:0]         w_hour_nxt;
    logic [5:0]         w_min_nxt;
    logic [5:0]         w_sec_nxt;

    always_comb begin
        w_rise     = tick_in & ~r_tick_q;
        w_accept   = load_valid & r_load_ready;
        w_load_ok  = (load_hour <= c_HOUR_MAX) && (load_min <= c_MS_MAX) && (load_sec <= c_MS_MAX);
        // A load in the same cycle takes precedence over any rise.
        w_count    = (r_state == ST_RUN) && w_rise && !w_accept;
        w_sec_evt  = w_count && (r_edge_cnt == c_EDGE_LAST);
        w_sec_nxt  = (r_sec == c_MS_MAX) ? 6'd0 : r_sec + 6'd1;
        w_min_nxt  = r_min;
        w_hour_nxt = r_hour;
        if (r_sec == c_MS_MAX) begin
            w_min_nxt = (r_min == c_MS_MAX) ? 6'd0 : r_min + 6'd1;
            if (r_min == c_MS_MAX) begin
                w_hour_nxt = (r_hour == c_HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_STOP;
            r_tick_q     <= 1'b0;
            r_edge_cnt   <= '0;
            r_hour       <= 5'd0;
            r_min        <= 6'd0;
            r_sec        <= 6'd0;
            r_sec_pulse  <= 1'b0;
            r_load_err   <= 1'b0;
            r_load_ready <= 1'b0;
        end else begin
            r_tick_q     <= tick_in;
            r_sec_pulse  <= 1'b0;
            r_load_err   <= 1'b0;
            r_load_ready <= !w_accept;

            case (r_state)
                ST_STOP: begin
                    if (w_accept)  r_state <= ST_LOAD;
                    else if (run)  r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept)  r_state <= ST_LOAD;
                    else if (!run) r_state <= ST_STOP;
                end
                ST_LOAD: r_state <= run ? ST_RUN : ST_STOP;
                default: r_state <= ST_STOP;
            endcase

            if (w_accept) begin
                if (w_load_ok) begin
                    r_hour     <= load_hour;
                    r_min      <= load_min;
                    r_sec      <= load_sec;
                    r_edge_cnt <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (w_count) begin
                if (w_sec_evt) begin
                    r_edge_cnt  <= '0;
                    r_sec_pulse <= 1'b1;
                    r_hour      <= w_hour_nxt;
                    r_min       <= w_min_nxt;
                    r_sec       <= w_sec_nxt;
                end else begin
                    r_edge_cnt  <= r_edge_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic r_alarm_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alarm_hit <= 1'b0;
        end else begin
            r_alarm_hit <= w_sec_evt && alarm_on && (w_hour_nxt == alarm_hour) &&
                           (w_min_nxt == alarm_min) && (w_sec_nxt == 6'd0);
        end
    end

    assign alarm_hit = r_alarm_hit;
`endif

    assign load_ready = r_load_ready;
    assign load_err   = r_load_err;
    assign hour       = r_hour;
    assign min        = r_min;
    assign sec        = r_sec;
    assign sec_pulse  = r_sec_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rtc_time_counter
// Description : Directed scoreboard bench for rtc_time_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       run;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       load_err;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_pulse;
`ifdef RTC_ALARM_EN
    logic       alarm_on;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_hit;
    int         alarm_cnt = 0;
`endif

    rtc_time_counter #(.EDGES_PER_SEC(5), .HOUR_MAX(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .run        (run),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_hour  (load_hour),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .load_err   (load_err),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .sec_pulse  (sec_pulse)
`ifdef RTC_ALARM_EN
        ,
        .alarm_on   (alarm_on),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_hit  (alarm_hit)
`endif
    );

    always #5 clk = ~clk;

    int pulse_cnt = 0;
    always @(negedge clk) begin
        if (sec_pulse === 1'b1) pulse_cnt++;
`ifdef RTC_ALARM_EN
        if (alarm_hit === 1'b1) alarm_cnt++;
`endif
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0h required=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] tm(input int h, input int m, input int s);
        return {15'd0, 5'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [31:0] now_t();
        return {15'd0, hour, min, sec};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rise(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            step();
        end
    endtask

    task automatic load(input int h, input int m, input int s);
        load_valid = 1'b1;
        load_hour  = 5'(h);
        load_min   = 6'(m);
        load_sec   = 6'(s);
        step();
        load_valid = 1'b0;
    endtask

    int base;

    initial begin
        rst_n = 1'b0; tick_in = 1'b0; run = 1'b0; load_valid = 1'b0;
        load_hour = '0; load_min = '0; load_sec = '0;
`ifdef RTC_ALARM_EN
        alarm_on = 1'b0; alarm_hour = '0; alarm_min = '0;
`endif
        repeat (3) step();

        // Reset state: {load_ready, load_err, sec_pulse} and time all zero
        push("reset_flags", 32'h0);
        pop_check({29'd0, load_ready, load_err, sec_pulse});
        push("reset_time", tm(0, 0, 0));
        pop_check(now_t());

        rst_n = 1'b1;
        step();
        push("ready_after_release", 32'd1);
        pop_check({31'd0, load_ready});

        // Five rises make one second; four do not
        run = 1'b1;
        step();
        base = pulse_cnt;
        rise(4);
        push("four_rises_time", tm(0, 0, 0));
        pop_check(now_t());
        rise(1);
        push("five_rises_time", tm(0, 0, 1));
        pop_check(now_t());
        push("five_rises_pulses", 32'(base + 1));
        pop_check(32'(pulse_cnt));

        // Full wrap 23:59:59 -> 00:00:00
        load(23, 59, 59);
        push("load_23_59_59", tm(23, 59, 59));
        pop_check(now_t());
        push("load_ready_low_in_load", 32'd0);
        pop_check({31'd0, load_ready});
        step();
        push("load_ready_back", 32'd1);
        pop_check({31'd0, load_ready});
        base = pulse_cnt;
        rise(5);
        push("wrap_midnight", tm(0, 0, 0));
        pop_check(now_t());
        push("wrap_pulses", 32'(base + 1));
        pop_check(32'(pulse_cnt));

        // Out-of-range minute rejected
        load(1, 60, 0);
        push("bad_load_err_ready", 32'b10);
        pop_check({30'd0, load_err, load_ready});
        push("bad_load_time", tm(0, 0, 0));
        pop_check(now_t());
        step();
        push("bad_load_err_clears", 32'b01);
        pop_check({30'd0, load_err, load_ready});

        // Load in the same cycle as the fifth rise: load wins, prescaler cleared
        rise(4);
        base = pulse_cnt;
        tick_in = 1'b1;
        load(12, 34, 56);
        push("load_vs_second_time", tm(12, 34, 56));
        pop_check(now_t());
        tick_in = 1'b0;
        step();
        push("load_vs_second_pulses", 32'(base));
        pop_check(32'(pulse_cnt));
        rise(4);
        push("edge_cnt_cleared_4", tm(12, 34, 56));
        pop_check(now_t());
        rise(1);
        push("edge_cnt_cleared_5", tm(12, 34, 57));
        pop_check(now_t());

        // Stop holds the prescaler without clearing it
        base = pulse_cnt;
        rise(3);
        run = 1'b0;
        step();
        rise(10);
        push("stopped_time", tm(12, 34, 57));
        pop_check(now_t());
        run = 1'b1;
        step();
        rise(1);
        push("resume_first_rise", tm(12, 34, 57));
        pop_check(now_t());
        rise(1);
        push("resume_second_rise", tm(12, 34, 58));
        pop_check(now_t());
        push("resume_pulses", 32'(base + 1));
        pop_check(32'(pulse_cnt));

        // Minute/hour carry, and a rise coinciding with run falling
        load(5, 59, 59);
        step();
        rise(5);
        push("carry_hour", tm(6, 0, 0));
        pop_check(now_t());
        rise(4);
        tick_in = 1'b1;
        run = 1'b0;
        step();
        tick_in = 1'b0;
        step();
        push("rise_with_run_drop", tm(6, 0, 1));
        pop_check(now_t());
        rise(5);
        push("stopped_after_drop", tm(6, 0, 1));
        pop_check(now_t());

        // Reset during a load request drops the load
        run = 1'b1;
        rst_n = 1'b0;
        load(10, 10, 10);
        push("mid_reset_time", tm(0, 0, 0));
        pop_check(now_t());
        push("mid_reset_ready", 32'd0);
        pop_check({31'd0, load_ready});
        rst_n = 1'b1;
        step();
        step();

`ifdef RTC_ALARM_EN
        alarm_hour = 5'd0;
        alarm_min  = 6'd1;
        alarm_on   = 1'b1;
        base = alarm_cnt;
        load(0, 1, 0);
        step();
        push("alarm_not_on_load", 32'(base));
        pop_check(32'(alarm_cnt));
        load(0, 0, 59);
        step();
        rise(5);
        push("alarm_hit_on", 32'(base + 1));
        pop_check(32'(alarm_cnt));
        alarm_on = 1'b0;
        load(0, 0, 59);
        step();
        rise(5);
        push("alarm_hit_off", 32'(base + 1));
        pop_check(32'(alarm_cnt));
        push("alarm_time", tm(0, 1, 0));
        pop_check(now_t());
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
